// File: rtl/selmap_load_ctrl.sv
// selmap_load_ctrl
//
// Sequences a complete SelectMAP configuration load. On an accepted start it
// pulses PROGRAM_B, waits for INIT_B, then pops one FIFO word per CCLK period
// and presents it on the SelectMAP bus. After the last word it keeps CCLK
// running until DONE rises. Runs entirely in the FIFO read-clock domain.
//
// Ports:
//   clk, rst            - clock (FIFO rd_clk), synchronous active-high reset
//   start, word_count   - load request and number of words to transfer
//   busy                - high whenever the controller is not idle
//   done, error         - one-cycle completion / failure pulses
//   error_code          - 0 zero length, 1 INIT timeout, 2 INIT_B low during
//                         load (CRC), 3 DONE timeout; held until next start
//   fifo_rd_en          - FIFO pop request
//   fifo_rd_data        - FIFO read data, valid with fifo_rd_data_valid
//   fifo_empty          - FIFO empty flag
//   fifo_rd_data_valid  - high the cycle after an accepted pop
//   selmap_program_b    - PROGRAM_B (active low)
//   selmap_init_b       - INIT_B from the device (synchronised)
//   selmap_done         - DONE from the device (synchronised)
//   selmap_cclk         - configuration clock, period CLK_DIV cycles
//   selmap_csi_b        - chip select (active low)
//   selmap_rdwr_b       - low while the controller owns the bus
//   selmap_data         - configuration data word

module selmap_load_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLK_DIV      = 20,
    parameter int CNT_WIDTH    = 32,
    parameter int PROG_CYCLES  = 64,
    parameter int INIT_TIMEOUT = 65535,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_data_valid,
    output logic                  selmap_program_b,
    input  logic                  selmap_init_b,
    input  logic                  selmap_done,
    output logic                  selmap_cclk,
    output logic                  selmap_csi_b,
    output logic                  selmap_rdwr_b,
    output logic [DATA_WIDTH-1:0] selmap_data
);

    localparam int HALF   = CLK_DIV / 2;
    localparam int PH_W   = $clog2(CLK_DIV);
    localparam int WT_MAX = (PROG_CYCLES > INIT_TIMEOUT) ? PROG_CYCLES : INIT_TIMEOUT;
    localparam int WT_W   = $clog2(WT_MAX + 1);
    localparam int PER_W  = $clog2(DONE_TIMEOUT + 1);

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(HALF - 1);
    localparam logic [WT_W-1:0]  PROG_LAST = WT_W'(PROG_CYCLES - 1);
    localparam logic [WT_W-1:0]  INIT_LAST = WT_W'(INIT_TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        PROG,
        WAIT_INIT,
        FETCH,
        LOAD,
        CLK_LO,
        CLK_HI,
        WAIT_DONE
    } state_t;

    state_t state, state_next;

    logic [PH_W-1:0]       phase_cnt, phase_next;
    logic [WT_W-1:0]       wait_cnt, wait_next;
    logic [PER_W-1:0]      per_cnt, per_next;
    logic [CNT_WIDTH-1:0]  word_cnt, word_next, word_dec;

    logic                  done_next;
    logic                  error_next;
    logic [1:0]            code_next;
    logic                  prog_b_next;
    logic                  cclk_next;
    logic                  csi_b_next;
    logic                  rdwr_b_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  crc_abort;

    assign busy = (state != IDLE);

    // Pop is combinational so it can never be raised against a stale empty
    // flag; it is also suppressed when INIT_B signals a CRC abort this cycle.
    assign fifo_rd_en = (state == FETCH) && !fifo_empty && selmap_init_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            phase_cnt        <= '0;
            wait_cnt         <= '0;
            per_cnt          <= '0;
            word_cnt         <= '0;
            done             <= 1'b0;
            error            <= 1'b0;
            error_code       <= 2'd0;
            selmap_program_b <= 1'b1;
            selmap_cclk      <= 1'b0;
            selmap_csi_b     <= 1'b1;
            selmap_rdwr_b    <= 1'b1;
            selmap_data      <= '0;
        end else begin
            state            <= state_next;
            phase_cnt        <= phase_next;
            wait_cnt         <= wait_next;
            per_cnt          <= per_next;
            word_cnt         <= word_next;
            done             <= done_next;
            error            <= error_next;
            error_code       <= code_next;
            selmap_program_b <= prog_b_next;
            selmap_cclk      <= cclk_next;
            selmap_csi_b     <= csi_b_next;
            selmap_rdwr_b    <= rdwr_b_next;
            selmap_data      <= data_next;
        end
    end

    always_comb begin
        state_next  = state;
        phase_next  = phase_cnt;
        wait_next   = wait_cnt;
        per_next    = per_cnt;
        word_next   = word_cnt;
        done_next   = 1'b0;
        error_next  = 1'b0;
        code_next   = error_code;
        prog_b_next = selmap_program_b;
        cclk_next   = selmap_cclk;
        csi_b_next  = selmap_csi_b;
        rdwr_b_next = selmap_rdwr_b;
        data_next   = selmap_data;

        // Word counter saturates at zero rather than wrapping.
        word_dec = (word_cnt == '0) ? '0 : word_cnt - CNT_WIDTH'(1);

        crc_abort = (state inside {FETCH, LOAD, CLK_LO, CLK_HI, WAIT_DONE}) && !selmap_init_b;

        case (state)
            IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        error_next = 1'b1;
                        code_next  = 2'd0;
                    end else begin
                        word_next   = word_count;
                        code_next   = 2'd0;
                        wait_next   = '0;
                        prog_b_next = 1'b0;
                        state_next  = PROG;
                    end
                end
            end

            PROG: begin
                if (wait_cnt == PROG_LAST) begin
                    prog_b_next = 1'b1;
                    wait_next   = '0;
                    state_next  = WAIT_INIT;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end

            WAIT_INIT: begin
                if (selmap_init_b) begin
                    rdwr_b_next = 1'b0;
                    state_next  = FETCH;
                end else if (wait_cnt == INIT_LAST) begin
                    error_next = 1'b1;
                    code_next  = 2'd1;
                    state_next = IDLE;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end

            FETCH: begin
                cclk_next = 1'b0;
                if (fifo_rd_en) begin
                    state_next = LOAD;
                end
            end

            LOAD: begin
                if (fifo_rd_data_valid) begin
                    data_next  = fifo_rd_data;
                    csi_b_next = 1'b0;
                    phase_next = '0;
                    state_next = CLK_LO;
                end
            end

            CLK_LO: begin
                if (phase_cnt == PH_LAST) begin
                    phase_next = '0;
                    cclk_next  = 1'b1;
                    state_next = CLK_HI;
                end else begin
                    phase_next = phase_cnt + 1'b1;
                end
            end

            CLK_HI: begin
                if (phase_cnt == PH_LAST) begin
                    phase_next = '0;
                    cclk_next  = 1'b0;
                    word_next  = word_dec;
                    if (word_dec == '0) begin
                        csi_b_next = 1'b1;
                        per_next   = '0;
                        state_next = WAIT_DONE;
                    end else begin
                        state_next = FETCH;
                    end
                end else begin
                    phase_next = phase_cnt + 1'b1;
                end
            end

            WAIT_DONE: begin
                if (selmap_done) begin
                    done_next   = 1'b1;
                    rdwr_b_next = 1'b1;
                    cclk_next   = 1'b0;
                    state_next  = IDLE;
                end else if (phase_cnt == PH_LAST) begin
                    phase_next = '0;
                    cclk_next  = ~selmap_cclk;
                    // A full CCLK period ends on each falling edge.
                    if (selmap_cclk) begin
                        if (per_cnt == PER_LAST) begin
                            error_next  = 1'b1;
                            code_next   = 2'd3;
                            rdwr_b_next = 1'b1;
                            cclk_next   = 1'b0;
                            state_next  = IDLE;
                        end else begin
                            per_next = per_cnt + 1'b1;
                        end
                    end
                end else begin
                    phase_next = phase_cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // INIT_B falling while loading is the device's CRC error indication;
        // it overrides whatever the current state decided.
        if (crc_abort) begin
            done_next   = 1'b0;
            error_next  = 1'b1;
            code_next   = 2'd2;
            csi_b_next  = 1'b1;
            cclk_next   = 1'b0;
            rdwr_b_next = 1'b1;
            state_next  = IDLE;
        end
    end

endmodule

// File: tb/tb_selmap_load_ctrl.sv
// tb_selmap_load_ctrl
//
// Directed bench for selmap_load_ctrl with a small FIFO model and a passive
// monitor that logs pops and the data word seen at each CCLK rising edge
// while chip select is active.

module tb_selmap_load_ctrl;

    localparam int DW = 32;
    localparam int CD = 4;
    localparam int CW = 16;
    localparam int PC = 64;
    localparam int IT = 100;
    localparam int DT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    error_code;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty;
    logic          fifo_rd_data_valid = 1'b0;
    logic          selmap_program_b;
    logic          selmap_init_b;
    logic          selmap_done;
    logic          selmap_cclk;
    logic          selmap_csi_b;
    logic          selmap_rdwr_b;
    logic [DW-1:0] selmap_data;

    always #5 clk = ~clk;

    selmap_load_ctrl #(
        .DATA_WIDTH  (DW),
        .CLK_DIV     (CD),
        .CNT_WIDTH   (CW),
        .PROG_CYCLES (PC),
        .INIT_TIMEOUT(IT),
        .DONE_TIMEOUT(DT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .word_count        (word_count),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .error_code        (error_code),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_empty        (fifo_empty),
        .fifo_rd_data_valid(fifo_rd_data_valid),
        .selmap_program_b  (selmap_program_b),
        .selmap_init_b     (selmap_init_b),
        .selmap_done       (selmap_done),
        .selmap_cclk       (selmap_cclk),
        .selmap_csi_b      (selmap_csi_b),
        .selmap_rdwr_b     (selmap_rdwr_b),
        .selmap_data       (selmap_data)
    );

    // FIFO model: words are written by the stimulus, made visible via avail.
    logic [DW-1:0] mem [0:63];
    int   wr_idx = 0;
    int   avail  = 0;
    int   rd_idx = 0;
    logic fifo_flush = 1'b0;

    assign fifo_empty = (rd_idx >= avail);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_idx             <= avail;
            fifo_rd_data_valid <= 1'b0;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data       <= mem[rd_idx];
            rd_idx             <= rd_idx + 1;
            fifo_rd_data_valid <= 1'b1;
        end else begin
            fifo_rd_data_valid <= 1'b0;
        end
    end

    // Monitor: samples values held during the cycle that ends at this edge.
    int            pops = 0, bad_pops = 0, ncap = 0, err_pulses = 0, done_pulses = 0;
    logic          prev_cclk = 1'b0;
    logic [DW-1:0] cap [0:63];

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pops++;
            if (fifo_empty) bad_pops++;
        end
        if (selmap_cclk && !prev_cclk && !selmap_csi_b && ncap < 64) begin
            cap[ncap] = selmap_data;
            ncap++;
        end
        prev_cclk = selmap_cclk;
        if (error) err_pulses++;
        if (done)  done_pulses++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return selmap_program_b;
            1:       return selmap_csi_b;
            2:       return selmap_cclk;
            3:       return done;
            4:       return error;
            default: return 1'b0;
        endcase
    endfunction

    // Waits (bounded) until the selected signal equals val; n = cycles waited.
    task automatic wait_for(input string tag, input int which, input logic val,
                            input int budget, output int n);
        n = 0;
        while (sig(which) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached"}, sig(which), val);
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_idx] = w;
        wr_idx++;
    endtask

    task automatic do_start(input logic [CW-1:0] wc);
        word_count = wc;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic flush_fifo();
        avail      = wr_idx;
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int base_pop, base_cap, base_err, base_done, stall_bad, low_seen;

        rst           = 1'b1;
        start         = 1'b0;
        word_count    = '0;
        selmap_init_b = 1'b0;
        selmap_done   = 1'b0;
        tick(3);

        // Reset values
        check("rst_busy",   busy, 0);
        check("rst_done",   done, 0);
        check("rst_error",  error, 0);
        check("rst_code",   error_code, 0);
        check("rst_rd_en",  fifo_rd_en, 0);
        check("rst_prog_b", selmap_program_b, 1);
        check("rst_cclk",   selmap_cclk, 0);
        check("rst_csi_b",  selmap_csi_b, 1);
        check("rst_rdwr_b", selmap_rdwr_b, 1);
        check("rst_data",   selmap_data, 0);
        rst = 1'b0;
        tick(1);

        // Nominal load of three words
        base_pop = pops; base_cap = ncap; base_err = err_pulses;
        push(32'hA5A5_0001); push(32'hA5A5_0002); push(32'hA5A5_0003);
        avail = wr_idx;
        do_start(3);
        check("nom_prog_low", selmap_program_b, 0);
        check("nom_busy", busy, 1);
        wait_for("nom_prog_release", 0, 1'b1, 200, n);
        check("nom_prog_cycles", n, PC);
        tick(10);
        selmap_init_b = 1'b1;
        wait_for("nom_csi_low", 1, 1'b0, 100, n);
        check("nom_rdwr_low", selmap_rdwr_b, 0);
        wait_for("nom_csi_high", 1, 1'b1, 200, n);
        tick(2 * CD);
        selmap_done = 1'b1;
        wait_for("nom_done", 3, 1'b1, 100, n);
        check("nom_busy_at_done", busy, 0);
        check("nom_rdwr_release", selmap_rdwr_b, 1);
        check("nom_data_hold", selmap_data, 32'hA5A5_0003);
        tick(1);
        selmap_done = 1'b0;
        check("nom_done_one_cycle", done, 0);
        check("nom_pops", pops - base_pop, 3);
        check("nom_edges", ncap - base_cap, 3);
        for (int i = 0; i < 3; i++)
            check("nom_word", cap[base_cap + i], 32'hA5A5_0001 + i);
        check("nom_no_error", err_pulses - base_err, 0);

        // FIFO stall between words
        base_pop = pops; base_cap = ncap;
        for (int i = 0; i < 4; i++) push(32'hC0DE_0001 + i);
        avail = wr_idx - 3;
        selmap_init_b = 1'b0;
        do_start(4);
        wait_for("stall_prog_release", 0, 1'b1, 200, n);
        tick(3);
        selmap_init_b = 1'b1;
        n = 0;
        while (pops - base_pop < 1 && n < 100) begin tick(1); n++; end
        check("stall_first_pop", pops - base_pop, 1);
        tick(10);
        stall_bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (selmap_cclk !== 1'b0 || selmap_csi_b !== 1'b0) stall_bad++;
            tick(1);
        end
        check("stall_bus_held", stall_bad, 0);
        check("stall_no_extra_pop", pops - base_pop, 1);
        avail = wr_idx;
        wait_for("stall_csi_high", 1, 1'b1, 300, n);
        tick(CD);
        selmap_done = 1'b1;
        wait_for("stall_done", 3, 1'b1, 100, n);
        tick(1);
        selmap_done = 1'b0;
        check("stall_pops", pops - base_pop, 4);
        check("stall_edges", ncap - base_cap, 4);
        for (int i = 0; i < 4; i++)
            check("stall_word", cap[base_cap + i], 32'hC0DE_0001 + i);

        // INIT timeout
        base_pop = pops;
        selmap_init_b = 1'b0;
        do_start(1);
        wait_for("it_prog_release", 0, 1'b1, 200, n);
        wait_for("it_error", 4, 1'b1, 300, n);
        check("it_latency", n, IT);
        check("it_code", error_code, 1);
        check("it_busy", busy, 0);
        check("it_no_pop", pops - base_pop, 0);
        tick(1);
        check("it_error_one_cycle", error, 0);
        check("it_code_held", error_code, 1);

        // Zero-length start
        do_start(0);
        check("zl_error", error, 1);
        check("zl_code", error_code, 0);
        check("zl_busy", busy, 0);
        low_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (selmap_program_b !== 1'b1) low_seen++;
            tick(1);
        end
        check("zl_prog_never_low", low_seen, 0);
        check("zl_error_cleared", error, 0);

        // CRC abort during word 2 of 5
        base_pop = pops;
        for (int i = 0; i < 5; i++) push(32'h5EED_0001 + i);
        avail = wr_idx;
        selmap_init_b = 1'b0;
        do_start(5);
        wait_for("crc_prog_release", 0, 1'b1, 200, n);
        tick(2);
        selmap_init_b = 1'b1;
        n = 0;
        while (pops - base_pop < 2 && n < 100) begin tick(1); n++; end
        check("crc_second_pop", pops - base_pop, 2);
        tick(2);
        selmap_init_b = 1'b0;
        tick(1);
        check("crc_error", error, 1);
        check("crc_code", error_code, 2);
        check("crc_csi_b", selmap_csi_b, 1);
        check("crc_cclk", selmap_cclk, 0);
        check("crc_busy", busy, 0);
        tick(20);
        check("crc_no_more_pops", pops - base_pop, 2);
        flush_fifo();

        // DONE timeout
        base_done = done_pulses;
        push(32'h7777_0001);
        avail = wr_idx;
        do_start(1);
        wait_for("dt_prog_release", 0, 1'b1, 200, n);
        tick(2);
        selmap_init_b = 1'b1;
        wait_for("dt_csi_low", 1, 1'b0, 100, n);
        wait_for("dt_csi_high", 1, 1'b1, 100, n);
        wait_for("dt_error", 4, 1'b1, 200, n);
        check("dt_latency", n, DT * CD);
        check("dt_code", error_code, 3);
        check("dt_cclk", selmap_cclk, 0);
        check("dt_busy", busy, 0);
        check("dt_rdwr_b", selmap_rdwr_b, 1);
        check("dt_no_done", done_pulses - base_done, 0);

        // Reset while in CLK_HI
        push(32'h1234_0001); push(32'h1234_0002);
        avail = wr_idx;
        selmap_init_b = 1'b0;
        do_start(2);
        wait_for("rs_prog_release", 0, 1'b1, 200, n);
        tick(2);
        selmap_init_b = 1'b1;
        wait_for("rs_clk_hi", 2, 1'b1, 100, n);
        base_err = err_pulses; base_done = done_pulses;
        rst = 1'b1;
        tick(1);
        check("rs_prog_b", selmap_program_b, 1);
        check("rs_csi_b",  selmap_csi_b, 1);
        check("rs_cclk",   selmap_cclk, 0);
        check("rs_busy",   busy, 0);
        check("rs_done",   done, 0);
        check("rs_error",  error, 0);
        rst = 1'b0;
        flush_fifo();
        tick(3);
        check("rs_no_error_pulse", err_pulses - base_err, 0);
        check("rs_no_done_pulse", done_pulses - base_done, 0);

        // Normal run after reset
        base_pop = pops; base_cap = ncap;
        push(32'hD00D_0001);
        avail = wr_idx;
        selmap_init_b = 1'b0;
        do_start(1);
        wait_for("ar_prog_release", 0, 1'b1, 200, n);
        check("ar_prog_cycles", n, PC);
        tick(2);
        selmap_init_b = 1'b1;
        wait_for("ar_csi_low", 1, 1'b0, 100, n);
        wait_for("ar_csi_high", 1, 1'b1, 100, n);
        tick(CD);
        selmap_done = 1'b1;
        wait_for("ar_done", 3, 1'b1, 100, n);
        tick(1);
        selmap_done = 1'b0;
        check("ar_pops", pops - base_pop, 1);
        check("ar_edges", ncap - base_cap, 1);
        check("ar_word", cap[base_cap], 32'hD00D_0001);
        check("ar_no_error", err_pulses - base_err, 0);

        check("pop_while_empty", bad_pops, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
